// File: rtl/axon_event_encoder.sv
// Turns rising edges of the neuron axon into {timestamp, V} event words held in a FWFT FIFO.
// Optional spike-rate window output is compiled in with `define AXON_EVENT_RATE_EN.
module axon_event_encoder #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
`ifdef AXON_EVENT_RATE_EN
  parameter int WIN   = 256,
`endif
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axon,
  input  logic [7:0]        V,
  input  logic              en,
  input  logic              clr_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TS_W+7:0]   out_data,
  output logic [AW:0]       level,
  output logic              overflow,
  output logic [7:0]        drop_cnt
`ifdef AXON_EVENT_RATE_EN
  ,
  output logic [7:0]        rate
`endif
);

  localparam int DW = TS_W + 8;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [TS_W-1:0] ts_q, ts_d;
  logic            axon_q;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [DW-1:0]   last_q, last_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic [7:0]      drop_base;

  logic spike, empty, full, push, pop, drop;

  // Handshake: a word transfers on a rising edge where out_valid & out_ready;
  // out_valid/out_data never change while out_valid=1 and out_ready=0.
  always_comb begin
    spike = axon & ~axon_q & en;
    empty = (level_q == '0);
    full  = (level_q == FULL_LVL);
    pop   = ~empty & out_ready;
    push  = spike & (~full | pop);
    drop  = spike & full & ~pop;
  end

  always_comb begin
    ts_d       = ts_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_d     = last_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    drop_base  = clr_ovf ? 8'd0 : drop_cnt_q;

    if (en) ts_d = ts_q + TS_W'(1);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // A drop on the same edge as clr_ovf restarts the count at one.
    if (clr_ovf) overflow_d = 1'b0;
    drop_cnt_d = drop_base;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_base != 8'hFF) drop_cnt_d = drop_base + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      axon_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_d;
      axon_q     <= axon;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; the pointers and level define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {ts_q, V};
  end

  assign out_valid = ~empty;
  assign out_data  = empty ? last_q : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

`ifdef AXON_EVENT_RATE_EN
  localparam int WCW = (WIN > 1) ? $clog2(WIN) : 1;

  logic [WCW-1:0] win_q, win_d;
  logic [7:0]     spk_q, spk_d, spk_inc;
  logic [7:0]     rate_q, rate_d;

  // Every spike counts toward the rate, including ones the FIFO had to drop.
  always_comb begin
    win_d   = win_q;
    spk_d   = spk_q;
    rate_d  = rate_q;
    spk_inc = (spike && spk_q != 8'hFF) ? spk_q + 8'd1 : spk_q;
    if (en) begin
      if (win_q == WCW'(WIN - 1)) begin
        win_d  = '0;
        rate_d = spk_inc;
        spk_d  = '0;
      end else begin
        win_d = win_q + WCW'(1);
        spk_d = spk_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      spk_q  <= '0;
      rate_q <= '0;
    end else begin
      win_q  <= win_d;
      spk_q  <= spk_d;
      rate_q <= rate_d;
    end
  end

  assign rate = rate_q;
`endif

endmodule
